// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment monitor/decoder (seg_decode).
// Segment patterns are active-high in the order a..g, which maps to bus bits [7:1].
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_PAT [0:7] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000   // 7
  };

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef struct packed {
    logic       en;
    logic       err;
    logic [2:0] num;
  } seg_dec_t;

  typedef enum logic {IDLE, SEND} seg_state_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [2:0] first_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_digit_dec.sv
// Combinational decoder for one active-low segment bus.
// Build option SEG_DP_CHECK_EN: a lit decimal point marks the digit as an error.
module seg_digit_dec
  import seg_pkg::*;
(
  input  logic [7:0] i_seg,
  output seg_dec_t   o_dec
);

  logic [7:0] lit;
  logic       hit;
  logic       dp_err;

  assign lit = ~i_seg;

`ifdef SEG_DP_CHECK_EN
  assign dp_err = lit[0];
`else
  assign dp_err = lit[0] & 1'b0;
`endif

  always_comb begin
    o_dec = '0;
    hit   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (lit[7:1] == SEG_PAT[k]) begin
        hit         = 1'b1;
        o_dec.num   = 3'(k);
      end
    end
    if (hit) begin
      o_dec.en = 1'b1;
    end else if (lit[7:1] != SEG_OFF) begin
      o_dec.err = 1'b1;
    end
    // The dp check overrides any recognised digit.
    if (dp_err) begin
      o_dec = '{en: 1'b0, err: 1'b1, num: 3'd0};
    end
  end

endmodule

// File: rtl/seg_decode.sv
// Glitch-filtered decoder for eight segment buses: commits a snapshot once the pins are
// stable and emits one valid/ready event per changed digit. Option: SEG_DP_CHECK_EN.
module seg_decode
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_seg0,
  input  logic [7:0]  i_seg1,
  input  logic [7:0]  i_seg2,
  input  logic [7:0]  i_seg3,
  input  logic [7:0]  i_seg4,
  input  logic [7:0]  i_seg5,
  input  logic [7:0]  i_seg6,
  input  logic [7:0]  i_seg7,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_idx,
  output logic [2:0]  o_num,
  output logic        o_blank,
  output logic        o_err,
  output logic [23:0] o_digits,
  output logic [7:0]  o_en,
  output logic [7:0]  o_err_mask
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

  logic [63:0]            pins;
  logic [63:0]            s_q, s_d;
  logic [7:0]             cnt_q, cnt_d;
  seg_dec_t               dec [NUM_DIGITS];
  seg_dec_t [7:0]         snap_q, snap_d;
  logic [7:0]             chg;
  logic [7:0]             pending_q, pending_d;
  seg_state_t             state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [2:0]             num_q, num_d;
  logic                   blank_q, blank_d;
  logic                   err_q, err_d;
  logic                   stable;
  logic                   commit;
  logic [2:0]             sel;

  assign pins = {i_seg7, i_seg6, i_seg5, i_seg4, i_seg3, i_seg2, i_seg1, i_seg0};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_digit_dec u_dec (
      .i_seg (s_q[8*g +: 8]),
      .o_dec (dec[g])
    );
  end

  // Commit fires only on the edge where the counter reaches its saturation value.
  always_comb begin
    s_d    = pins;
    stable = (pins == s_q);
    cnt_d  = cnt_q;
    if (!stable) begin
      cnt_d = 8'd0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
    commit = stable && (cnt_q == CNT_PRE);
    snap_d = snap_q;
    chg    = '0;
    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_d[i] = dec[i];
        chg[i]    = (dec[i] != snap_q[i]);
      end
    end
  end

  // Payload is taken from snap_d so a commit on the load edge is never reported stale.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | chg;
    idx_d     = idx_q;
    num_d     = num_q;
    blank_d   = blank_q;
    err_d     = err_q;
    sel       = first_set(pending_q);
    case (state_q)
      IDLE: begin
        if (pending_q != 8'd0) begin
          idx_d   = sel;
          num_d   = snap_d[sel].num;
          blank_d = ~snap_d[sel].en & ~snap_d[sel].err;
          err_d   = snap_d[sel].err;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_ready) begin
          pending_d[idx_q] = chg[idx_q];
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_digits   = '0;
    o_en       = '0;
    o_err_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      o_digits[3*i +: 3] = snap_q[i].num;
      o_en[i]            = snap_q[i].en;
      o_err_mask[i]      = snap_q[i].err;
    end
  end

  assign o_valid = (state_q == SEND);
  assign o_idx   = idx_q;
  assign o_num   = num_q;
  assign o_blank = blank_q;
  assign o_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '1;
      cnt_q     <= CNT_MAX;
      snap_q    <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      blank_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
    end
  end

endmodule
